// File: rtl/rv_reg_imm_alu_pkg.sv
// rv_reg_imm_alu_pkg: opcode, ALU code and reset-value constants for the execute core
package rv_reg_imm_alu_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;
  localparam logic [31:0] SP_RESET_DEF = 32'h0000_03FC;
  localparam logic [31:0] GP_RESET_DEF = 32'h0000_0000;
endpackage

// File: rtl/rv_reg_imm_alu_if.sv
// rv_reg_imm_alu_if: instruction/writeback inputs and operand/result outputs of the execute core
interface rv_reg_imm_alu_if;
  logic [31:0] iInstr;
  logic        iRegWrite;
  logic [31:0] iWriteData;
  logic        iALUSrc;
  logic [2:0]  iALUControl;
  logic [4:0]  iRegDispSelect;
  logic [31:0] oReadData1;
  logic [31:0] oReadData2;
  logic [31:0] oImm;
  logic [31:0] oALUResult;
  logic        oZero;
  logic [31:0] oRegDisp;
  modport master (
    output iInstr, iRegWrite, iWriteData, iALUSrc, iALUControl, iRegDispSelect,
    input  oReadData1, oReadData2, oImm, oALUResult, oZero, oRegDisp
  );
  modport slave (
    input  iInstr, iRegWrite, iWriteData, iALUSrc, iALUControl, iRegDispSelect,
    output oReadData1, oReadData2, oImm, oALUResult, oZero, oRegDisp
  );
endinterface

// File: rtl/rv_regfile.sv
// rv_regfile: 32x32 register file, x0 hardwired to 0, three combinational read ports without bypass
module rv_regfile
  import rv_reg_imm_alu_pkg::*;
#(
  parameter logic [31:0] SP_RESET = SP_RESET_DEF,
  parameter logic [31:0] GP_RESET = GP_RESET_DEF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  // next state: apply the write unless it targets x0
  always_comb begin
    regs_d = regs_q;
    if (we && wa != 5'd0) regs_d[wa] = wd;
  end
  // register array with asynchronous reset to the pointer defaults
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= (i == 2) ? SP_RESET : (i == 3) ? GP_RESET : 32'd0;
    end else begin
      regs_q <= regs_d;
    end
  end
  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
  assign rd3 = regs_q[ra3];
endmodule

// File: rtl/rv_reg_imm_alu.sv
// rv_reg_imm_alu: register file, immediate generator and ALU of the single-cycle RV32I datapath
module rv_reg_imm_alu
  import rv_reg_imm_alu_pkg::*;
#(
  parameter logic [31:0] SP_RESET = SP_RESET_DEF,
  parameter logic [31:0] GP_RESET = GP_RESET_DEF
) (
  input logic iCLK,
  input logic iRST,
  rv_reg_imm_alu_if.slave bus
);
  logic [31:0] instr, imm, a, b, res;
  alu_op_e     op;
  assign instr = bus.iInstr;
  rv_regfile #(.SP_RESET(SP_RESET), .GP_RESET(GP_RESET)) u_rf (
    .iCLK (iCLK),
    .iRST (iRST),
    .we   (bus.iRegWrite),
    .wa   (instr[11:7]),
    .wd   (bus.iWriteData),
    .ra1  (instr[19:15]),
    .ra2  (instr[24:20]),
    .ra3  (bus.iRegDispSelect),
    .rd1  (a),
    .rd2  (bus.oReadData2),
    .rd3  (bus.oRegDisp)
  );
  // immediate generation by instruction format
  always_comb begin
    imm = 32'd0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:                     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:                    imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_JAL:                       imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_LUI, OPC_AUIPC:            imm = {instr[31:12], 12'd0};
      default:                       imm = 32'd0;
    endcase
  end
  assign b  = bus.iALUSrc ? imm : bus.oReadData2;
  assign op = alu_op_e'(bus.iALUControl);
  // ALU operation select; add/sub wrap modulo 2^32
  always_comb begin
    res = 32'd0;
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_ADD: res = a + b;
      ALU_XOR: res = a ^ b;
      ALU_SLL: res = a << b[4:0];
      ALU_SRL: res = a >> b[4:0];
      ALU_SUB: res = a - b;
      ALU_SLT: res = {31'd0, $signed(a) < $signed(b)};
      default: res = 32'd0;
    endcase
  end
  assign bus.oReadData1 = a;
  assign bus.oImm       = imm;
  assign bus.oALUResult = res;
  assign bus.oZero      = (res == 32'd0);
endmodule

// File: tb/tb_rv_reg_imm_alu.sv
// tb_rv_reg_imm_alu: directed vectors for register file, immediate generator and ALU
module tb_rv_reg_imm_alu;
  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  int errs = 0;
  int checks = 0;
  rv_reg_imm_alu_if bus ();
  rv_reg_imm_alu dut (.iCLK(iCLK), .iRST(iRST), .bus(bus));
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [6:0] opc);
    return {7'd0, rs2, rs1, 3'd0, rd, opc};
  endfunction
  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    bus.iInstr = mk(5'd0, 5'd0, rd, 7'h33);
    bus.iWriteData = d;
    bus.iRegWrite = 1'b1;
    @(posedge iCLK);
    #1;
    bus.iRegWrite = 1'b0;
  endtask
  task automatic alu(input string tag, input logic [2:0] c, input logic [31:0] exp);
    bus.iALUControl = c;
    #1;
    chk(tag, bus.oALUResult, exp);
  endtask
  logic [31:0] imm_in [6] = '{32'hFFF00093, 32'hFE112E23, 32'hFE0008E3, 32'h008000EF, 32'h12345037, 32'h00000033};
  logic [31:0] imm_ex [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF0, 32'h00000008, 32'h12345000, 32'h00000000};
  initial begin
    bus.iInstr = '0;
    bus.iRegWrite = 1'b0;
    bus.iWriteData = '0;
    bus.iALUSrc = 1'b0;
    bus.iALUControl = 3'd0;
    bus.iRegDispSelect = 5'd0;
    #12;
    for (int i = 0; i < 4; i++) begin
      bus.iRegDispSelect = 5'(i);
      #1;
      chk($sformatf("rst_x%0d", i), bus.oRegDisp, (i == 2) ? 32'h3FC : 32'h0);
    end
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    bus.iInstr = mk(5'd5, 5'd0, 5'd5, 7'h33);
    bus.iWriteData = 32'hDEADBEEF;
    bus.iRegWrite = 1'b1;
    #1;
    chk("x5_before_edge", bus.oReadData1, 32'h0);
    @(posedge iCLK);
    #1;
    bus.iRegWrite = 1'b0;
    chk("x5_after_edge", bus.oReadData1, 32'hDEADBEEF);
    wr(5'd0, 32'h1234);
    bus.iRegDispSelect = 5'd0;
    bus.iInstr = mk(5'd0, 5'd0, 5'd0, 7'h33);
    #1;
    chk("x0_disp", bus.oRegDisp, 32'h0);
    chk("x0_rd1", bus.oReadData1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      bus.iInstr = imm_in[i];
      #1;
      chk($sformatf("imm_%h", imm_in[i]), bus.oImm, imm_ex[i]);
    end
    wr(5'd1, 32'd7);
    wr(5'd2, 32'hFFFFFFFE);
    bus.iInstr = mk(5'd1, 5'd2, 5'd0, 7'h33);
    bus.iALUSrc = 1'b0;
    #1;
    chk("rd2_x2", bus.oReadData2, 32'hFFFFFFFE);
    alu("add", 3'b010, 32'd5);
    alu("sub", 3'b110, 32'd9);
    alu("and", 3'b000, 32'd6);
    alu("or", 3'b001, 32'hFFFFFFFF);
    alu("xor", 3'b011, 32'hFFFFFFF9);
    alu("slt_12", 3'b111, 32'd0);
    bus.iInstr = mk(5'd2, 5'd1, 5'd0, 7'h33);
    alu("slt_21", 3'b111, 32'd1);
    wr(5'd1, 32'h80000001);
    bus.iInstr = 32'h00408013;
    bus.iALUSrc = 1'b1;
    alu("sll_imm", 3'b100, 32'h00000010);
    alu("srl_imm", 3'b101, 32'h08000000);
    wr(5'd1, 32'h55);
    wr(5'd2, 32'h55);
    bus.iInstr = mk(5'd1, 5'd2, 5'd0, 7'h33);
    bus.iALUSrc = 1'b0;
    alu("sub_eq", 3'b110, 32'd0);
    chk("zero_sub", {31'd0, bus.oZero}, 32'd1);
    alu("add_55", 3'b010, 32'hAA);
    chk("zero_add_55", {31'd0, bus.oZero}, 32'd0);
    wr(5'd1, 32'hFFFFFFFF);
    bus.iInstr = 32'h00108013;
    bus.iALUSrc = 1'b1;
    alu("add_wrap", 3'b010, 32'd0);
    chk("zero_wrap", {31'd0, bus.oZero}, 32'd1);
    bus.iInstr = mk(5'd0, 5'd0, 5'd7, 7'h33);
    bus.iWriteData = 32'h99;
    bus.iRegWrite = 1'b1;
    #2;
    iRST = 1'b0;
    @(posedge iCLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.iRegDispSelect = 5'(i);
      #1;
      chk($sformatf("mid_rst_x%0d", i), bus.oRegDisp, (i == 2) ? 32'h3FC : 32'h0);
    end
    bus.iRegWrite = 1'b0;
    @(negedge iCLK);
    iRST = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rv_reg_imm_alu.md
Name: rv_reg_imm_alu

Overview:
- Execute-side core of the single-cycle RV32I datapath: 32x32 register file, immediate generator and 3-bit-controlled ALU, with the ALU B-operand select built in.
- Receives the fetched instruction word and writeback data from the surrounding datapath.
- Returns register operands, the immediate, the ALU result and a debug register view.

Parameters:
- SP_RESET, 32'h0000_03FC, reset value of x2 (stack pointer).
- GP_RESET, 32'h0000_0000, reset value of x3 (global pointer).

Ports:
- iCLK  in  1  system clock; only clock, all state on rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iInstr  in  32  current instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
- iRegWrite  in  1  register write enable.
- iWriteData  in  32  writeback data for rd.
- iALUSrc  in  1  ALU B select: 0=rs2 data, 1=immediate.
- iALUControl  in  3  ALU operation code.
- iRegDispSelect  in  5  debug register index.
- oReadData1  out  32  rs1 contents.
- oReadData2  out  32  rs2 contents.
- oImm  out  32  sign-extended immediate.
- oALUResult  out  32  ALU result.
- oZero  out  1  1 when oALUResult == 0.
- oRegDisp  out  32  contents of register iRegDispSelect.

Behaviour:
- Clock and reset: one clock iCLK; reset iRST is asynchronous and active-low.
- Reset (iRST=0, asynchronous):
  - all registers cleared to 0, except x2=SP_RESET and x3=GP_RESET;
  - reset overrides any write in that cycle.
- Write:
  - on rising iCLK with iRST=1 and iRegWrite=1, reg[rd] <= iWriteData;
  - a write with rd=0 is discarded; x0 always reads 0.
- Reads are combinational (oReadData1, oReadData2, oRegDisp) with no write-through bypass:
  - data written at an edge is visible only after that edge;
  - reading rd in the same cycle returns the old value.
- ImmGen, combinational on opcode:
  - I-type (0000011, 0010011, 1100111): sext(instr[31:20]);
  - S-type (0100011): sext({[31:25],[11:7]});
  - B-type (1100011): sext({[31],[7],[30:25],[11:8],1'b0});
  - J-type (1101111): sext({[31],[19:12],[20],[30:21],1'b0});
  - U-type (0110111, 0010111): {[31:12],12'b0};
  - any other opcode: 0.
- ALU B operand = iALUSrc ? oImm : oReadData2.
- ALU, combinational, A = oReadData1:
  - 000 AND; 001 OR; 010 ADD; 011 XOR;
  - 100 SLL by B[4:0]; 101 SRL by B[4:0];
  - 110 SUB (A-B); 111 SLT (signed, result 1 or 0).
- Arithmetic: ADD/SUB wrap modulo 2^32, no overflow flag.
- oZero is derived from the final result.
- No internal latency beyond the register-file write edge. No handshakes.

Decomposition:
- Shared package holds:
  - opcode constants (OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC);
  - ALU code constants (ALU_AND … ALU_SLT);
  - SP_RESET/GP_RESET defaults.
- One sub-module is natural: rv_regfile (storage, reset, write, three read ports).
- ImmGen and ALU are combinational logic in the top.

Test Plan:
- Reset: assert iRST=0 mid-operation with iRegWrite=1 -> all regs read 0 except x2=0x3FC; oRegDisp with select 2 = 0x3FC.
- Write/read and x0:
  - write 0xDEADBEEF to x5 -> instr rs1=5 gives oReadData1=0xDEADBEEF only after the edge;
  - write 0x1234 to x0 -> x0 still reads 0.
- ImmGen:
  - 0xFFF00093 (addi x1,x0,-1) -> oImm=0xFFFFFFFF;
  - 0xFE112E23 (sw x1,-4(x2)) -> 0xFFFFFFFC;
  - 0xFE0008E3 (beq offset -16) -> 0xFFFFFFF0;
  - 0x008000EF (jal +8) -> 0x00000008;
  - 0x12345037 (lui) -> 0x12345000;
  - 0x00000033 (R-type) -> 0.
- ALU with x1=7, x2=0xFFFFFFFE, iALUSrc=0:
  - ADD -> 5; SUB -> 9; AND -> 6; OR -> 0xFFFFFFFF; XOR -> 0xFFFFFFF9;
  - SLT(x1,x2) -> 0; SLT(x2,x1) -> 1.
- Shifts/imm: x1=0x80000001, iALUSrc=1, imm=4:
  - SLL -> 0x00000010; SRL -> 0x08000000.
- Zero flag: SUB with equal operands 0x55 -> oALUResult=0, oZero=1; ADD 0xFFFFFFFF+1 -> 0, oZero=1.
